pwm_dac_out: RTL and testbench



---
 rtl/sine_dac_pkg.sv | 14 +
 rtl/pwm_dac_out_if.sv | 35 +++
 rtl/pwm_deadtime_gen.sv | 38 +++
 rtl/pwm_dac_out.sv | 100 ++++++++++
 tb/tb_pwm_dac_out.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_dac_pkg.sv
// Shared types and constants for the sine generator / PWM DAC pair.
// States, amplitude width and default dead time live here.
package sine_dac_pkg;

  localparam int AMP_WIDTH    = 10;
  localparam int DEADTIME_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/pwm_dac_out_if.sv
// Sample-in / PWM-out bundle between the sine source, the DAC stage
// and the SoC.
interface pwm_dac_out_if #(
  parameter int WIDTH = 10
);

  logic             en;
  logic [WIDTH-1:0] data_sin;
  logic             pwm_p;
  logic             pwm_n;
  logic [WIDTH-1:0] duty_q;
  logic             period_start;
  logic             busy;

  modport master (
    output en,
    output data_sin,
    input  pwm_p,
    input  pwm_n,
    input  duty_q,
    input  period_start,
    input  busy
  );

  modport slave (
    input  en,
    input  data_sin,
    output pwm_p,
    output pwm_n,
    output duty_q,
    output period_start,
    output busy
  );

endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM pair with per-output dead time; a rising edge
// waits DEADTIME cycles of steady request, so short pulses vanish.
module pwm_deadtime_gen #(
  parameter int DEADTIME = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic raw,
  output logic pwm_p,
  output logic pwm_n
);

  localparam logic [3:0] DT = 4'(DEADTIME);

  logic       raw_n;
  logic [3:0] cnt_p;
  logic [3:0] cnt_n;

  assign raw_n = active & ~raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p <= '0;
      cnt_n <= '0;
      pwm_p <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      if (!raw)            cnt_p <= '0;
      else if (cnt_p != DT) cnt_p <= cnt_p + 4'd1;
      if (!raw_n)          cnt_n <= '0;
      else if (cnt_n != DT) cnt_n <= cnt_n + 4'd1;
      pwm_p <= raw & (cnt_p == DT);
      pwm_n <= raw_n & (cnt_n == DT);
    end
  end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM DAC stage: one sample per 2**WIDTH-cycle period, clean drain on stop.
// Define PWM_DEADTIME_EN for the complementary dead-time output pair.
module pwm_dac_out
  import sine_dac_pkg::*;
#(
  parameter int WIDTH    = AMP_WIDTH,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input logic        clk,
  input logic        rst_n,
  pwm_dac_out_if.slave io
);

  if (DEADTIME < 1 || DEADTIME > 15) begin : g_bad_dt
    $error("DEADTIME out of range 1..15");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic             period_start;
  logic             latch;
  logic             wrap;
  logic             busy;
  logic             raw;
  logic             pwm_p;
  logic             pwm_n;

  assign wrap = (cnt == '1);
  assign busy = (state != IDLE);
  assign raw  = busy && (cnt < duty_q);

  // A wrap with en low never latches; DRAIN runs the period out first.
  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.en) begin
          state_nx = RUN;
          latch    = 1'b1;
        end
      end
      RUN: begin
        if (!io.en)    state_nx = DRAIN;
        else if (wrap) latch    = 1'b1;
      end
      DRAIN: begin
        if (io.en) begin
          state_nx = RUN;
          latch    = wrap;
        end else if (wrap) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_q       <= '0;
      period_start <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= busy ? cnt + 1'b1 : '0;
      period_start <= latch;
      if (latch) duty_q <= io.data_sin;
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime_gen #(
    .DEADTIME (DEADTIME)
  ) u_dt (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (busy),
    .raw    (raw),
    .pwm_p  (pwm_p),
    .pwm_n  (pwm_n)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_p <= 1'b0;
    else        pwm_p <= raw;
  end
  assign pwm_n = 1'b0;
`endif

  assign io.pwm_p        = pwm_p;
  assign io.pwm_n        = pwm_n;
  assign io.duty_q       = duty_q;
  assign io.period_start = period_start;
  assign io.busy         = busy;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Randomized bench for pwm_dac_out against a period-level reference model.
// Build with PWM_DEADTIME_EN to cover the dead-time output pair.
module tb_pwm_dac_out;
  import sine_dac_pkg::*;

  localparam int W = 10;
  localparam int P = 1 << W;
`ifdef PWM_DEADTIME_EN
  localparam int DT = 2;
`else
  localparam int DT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   samp[8];

  pwm_dac_out_if #(.WIDTH(W)) io();

  pwm_dac_out #(
    .WIDTH    (W),
    .DEADTIME (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare request in cycle k since entry: cnt = k mod P against the
  // sample latched at the start of that period.
  function automatic bit raw_at(int k, bit neg);
    bit hi;
    if (k < 0) return 1'b0;
    hi = (k % P) < samp[k / P];
    return neg ? !hi : hi;
  endfunction

  // Pin is the request delayed one cycle, held for DT extra cycles.
  function automatic bit exp_out(int k, bit neg);
    bit r = 1'b1;
    for (int i = 1; i <= DT + 1; i++) r &= raw_at(k - i, neg);
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    io.en = 1'b0;
    io.data_sin = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    io.en = 1'b0;
    io.data_sin = '0;
    step();
    checks += 5;
    if (io.pwm_p !== 1'b0) begin
      errors++; $display("FAIL reset_pwm_p got=%b want=0", io.pwm_p);
    end
    if (io.pwm_n !== 1'b0) begin
      errors++; $display("FAIL reset_pwm_n got=%b want=0", io.pwm_n);
    end
    if (io.duty_q !== '0) begin
      errors++; $display("FAIL reset_duty_q got=%0d want=0", io.duty_q);
    end
    if (io.period_start !== 1'b0) begin
      errors++; $display("FAIL reset_period_start got=%b want=0", io.period_start);
    end
    if (io.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", io.busy);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (io.busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy got=%b want=0", io.busy);
    end
  endtask

  // mode 0: held base, 1: ramp every clk, 2: random every clk
  task automatic run_test(string name, int nper, int mode, int base,
                          int drop_k, int rise_k);
    int e_duty, e_ps, e_p, e_n, e_busy, ov, per, d, n, e_drain;
    e_duty = 0; e_ps = 0; e_p = 0; e_n = 0; e_busy = 0; ov = 0;
    e_drain = 0;
    case (mode)
      0: samp[0] = base;
      1: samp[0] = base % P;
      default: samp[0] = int'($urandom_range(0, P - 1));
    endcase
    io.data_sin = W'(samp[0]);
    io.en = 1'b1;
    step();
    for (int k = 0; k < nper * P; k++) begin
      per = k / P;
      if (io.duty_q !== W'(samp[per])) e_duty++;
      if (io.period_start !== (k % P == 0)) e_ps++;
      if (io.pwm_p !== exp_out(k, 1'b0)) e_p++;
`ifdef PWM_DEADTIME_EN
      if (io.pwm_n !== exp_out(k, 1'b1)) e_n++;
      if (io.pwm_p & io.pwm_n) ov++;
`else
      if (io.pwm_n !== 1'b0) e_n++;
`endif
      if (io.busy !== 1'b1) e_busy++;
      case (mode)
        0: d = base;
        1: d = (base + k + 1) % P;
        default: d = int'($urandom_range(0, P - 1));
      endcase
      io.data_sin = W'(d);
      if ((k + 1) % P == 0) samp[(k + 1) / P] = d;
      if (k == drop_k) io.en = 1'b0;
      if (k == rise_k) io.en = 1'b1;
      step();
    end
    io.en = 1'b0;
    n = 0;
    while (io.busy === 1'b1 && n < 1100) begin
      step();
      n++;
      if (io.period_start !== 1'b0) e_drain++;
    end
    checks += 8;
    if (e_duty !== 0) begin
      errors++; $display("FAIL %s duty_q bad_cycles=%0d want=0", name, e_duty);
    end
    if (e_ps !== 0) begin
      errors++; $display("FAIL %s period_start bad_cycles=%0d want=0", name, e_ps);
    end
    if (e_p !== 0) begin
      errors++; $display("FAIL %s pwm_p bad_cycles=%0d want=0", name, e_p);
    end
    if (e_n !== 0) begin
      errors++; $display("FAIL %s pwm_n bad_cycles=%0d want=0", name, e_n);
    end
    if (e_busy !== 0) begin
      errors++; $display("FAIL %s busy bad_cycles=%0d want=0", name, e_busy);
    end
    if (ov !== 0) begin
      errors++; $display("FAIL %s overlap cycles=%0d want=0", name, ov);
    end
    if (n !== P) begin
      errors++; $display("FAIL %s drain_len got=%0d want=%0d", name, n, P);
    end
    if (e_drain !== 0) begin
      errors++; $display("FAIL %s drain_period_start got=%0d want=0", name, e_drain);
    end
  endtask

  task automatic test_held();
    run_test("held_256", 3, 0, 256, -1, -1);
    run_test("held_rand", 2, 0, int'($urandom_range(1, P - 2)), -1, -1);
  endtask

  task automatic test_boundary();
    run_test("duty_zero", 3, 0, 0, -1, -1);
    run_test("duty_max", 2, 0, P - 1, -1, -1);
  endtask

  task automatic test_ramp();
    run_test("ramp", 2, 1, int'($urandom_range(0, P - 1)), -1, -1);
    run_test("random", 2, 2, 0, -1, -1);
  endtask

  task automatic test_drain();
    int e_busy, e_ps, e_p;
    e_busy = 0; e_ps = 0; e_p = 0;
    samp[0] = int'($urandom_range(1, P - 2));
    io.data_sin = W'(samp[0]);
    io.en = 1'b1;
    step();
    for (int k = 0; k < P; k++) begin
      if (io.busy !== 1'b1) e_busy++;
      if (io.period_start !== (k == 0)) e_ps++;
      if (io.pwm_p !== exp_out(k, 1'b0)) e_p++;
      if (k == 100) io.en = 1'b0;
      io.data_sin = W'($urandom_range(0, P - 1));
      step();
    end
    checks += 6;
    if (io.busy !== 1'b0) begin
      errors++; $display("FAIL drain_end busy got=%b want=0", io.busy);
    end
    if (io.period_start !== 1'b0) begin
      errors++; $display("FAIL drain_end period_start got=%b want=0", io.period_start);
    end
    for (int k = 0; k < 8; k++) begin
      if (io.pwm_p !== 1'b0 || io.busy !== 1'b0) e_p++;
      step();
    end
    if (e_busy !== 0) begin
      errors++; $display("FAIL drain busy bad_cycles=%0d want=0", e_busy);
    end
    if (e_ps !== 0) begin
      errors++; $display("FAIL drain period_start bad_cycles=%0d want=0", e_ps);
    end
    if (e_p !== 0) begin
      errors++; $display("FAIL drain pwm_p bad_cycles=%0d want=0", e_p);
    end
    if (io.pwm_n !== 1'b0) begin
      errors++; $display("FAIL drain_idle pwm_n got=%b want=0", io.pwm_n);
    end
  endtask

  task automatic test_back_to_back();
    run_test("redrain", 2, 2, 0, 100, 600);
  endtask

  task automatic test_reset_mid();
    samp[0] = 700;
    io.data_sin = W'(700);
    io.en = 1'b1;
    step();
    for (int k = 0; k < 500; k++) step();
    checks += 5;
    if (io.pwm_p !== exp_out(500, 1'b0)) begin
      errors++; $display("FAIL mid_pre pwm_p got=%b want=%b", io.pwm_p, exp_out(500, 1'b0));
    end
    rst_n = 1'b0;
    #1;
    if (io.pwm_p !== 1'b0) begin
      errors++; $display("FAIL mid_rst pwm_p got=%b want=0", io.pwm_p);
    end
    if (io.busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst busy got=%b want=0", io.busy);
    end
    if (io.duty_q !== '0) begin
      errors++; $display("FAIL mid_rst duty_q got=%0d want=0", io.duty_q);
    end
    io.en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    if (io.busy !== 1'b0) begin
      errors++; $display("FAIL mid_release busy got=%b want=0", io.busy);
    end
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    int ov, gap, ngaps, bad, hits;
    bit seen;
    ov = 0; gap = 0; ngaps = 0; bad = 0; hits = 0; seen = 1'b0;
    io.data_sin = W'(512);
    io.en = 1'b1;
    step();
    for (int k = 0; k < 1100; k++) begin
      if (io.pwm_p & io.pwm_n) ov++;
      if (!io.pwm_p && !io.pwm_n) begin
        gap++;
      end else begin
        if (seen && gap > 0) begin
          ngaps++;
          if (gap != DT) bad++;
        end
        seen = 1'b1;
        gap = 0;
      end
      step();
    end
    checks += 4;
    if (ov !== 0) begin
      errors++; $display("FAIL dt_overlap cycles=%0d want=0", ov);
    end
    if (bad !== 0) begin
      errors++; $display("FAIL dt_gap wrong_gaps=%0d want=0", bad);
    end
    if (ngaps !== 2) begin
      errors++; $display("FAIL dt_gap_count got=%0d want=2", ngaps);
    end
    do_reset();
    io.data_sin = W'(1);
    io.en = 1'b1;
    step();
    for (int k = 0; k < 2 * P; k++) begin
      if (io.pwm_p !== 1'b0) hits++;
      step();
    end
    if (hits !== 0) begin
      errors++; $display("FAIL dt_short_pulse pwm_p_high=%0d want=0", hits);
    end
    do_reset();
  endtask
`endif

  initial begin
    io.en = 1'b0;
    io.data_sin = '0;
    test_reset();
    test_held();
    test_boundary();
    test_ramp();
    test_drain();
    test_back_to_back();
    test_reset_mid();
`ifdef PWM_DEADTIME_EN
    run_test("dt_512", 1, 0, 512, -1, -1);
    test_deadtime();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
